// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle control FSM for the single-memory MIPS-subset CPU
//
// Sequences the shared memory, ALU and register file through
// fetch/decode/execute/memory/writeback. Memory states stall on mem_ready
// and fall into HALT with bus_err set if the memory stays silent too long.
//
// Parameters:
//   WAIT_LIMIT     consecutive not-ready cycles tolerated in a memory state (0 = no timeout)
//   CNT_W          width of the retired-instruction counter
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   opcode         IR[31:26], used in DECODE and MEMADR
//   mem_ready      memory completes the current access this cycle
//   pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
//   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
//   pc_source      datapath controls, a function of the current state
//   state          current state encoding (debug)
//   bus_err        sticky memory timeout flag
//   illegal        sticky unsupported-opcode / bad-state flag
//   instr_count    retired-instruction count, wraps

module multicycle_ctrl #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             bus_err,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXEC    = 4'd6;
    localparam logic [3:0] S_RWB     = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_JUMP    = 4'd9;
    localparam logic [3:0] S_ADDI_EX = 4'd10;
    localparam logic [3:0] S_ADDI_WB = 4'd11;
    localparam logic [3:0] S_HALT    = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // wait_cnt only has to reach WAIT_LIMIT-1; the state leaves right after.
    localparam int WCW = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

    logic [3:0]     state_q;
    logic [3:0]     state_d;
    logic [WCW-1:0] wait_cnt;
    logic           is_mem_state;
    logic           timeout;
    logic           set_bus_err;
    logic           set_illegal;
    logic           retiring_state;
    logic           retire;

    assign state = state_q;

    assign is_mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                          (state_q == S_MEMWR);

    // A ready arriving in the last tolerated cycle wins over the timeout.
    assign timeout = (WAIT_LIMIT > 0) && !mem_ready && (wait_cnt == WAIT_LAST);

    assign retiring_state = (state_q == S_MEMWB)  || (state_q == S_MEMWR)  ||
                            (state_q == S_RWB)    || (state_q == S_BRANCH) ||
                            (state_q == S_JUMP)   || (state_q == S_ADDI_WB);

    // Counted only on the edge back into FETCH, never on entry to HALT.
    assign retire = retiring_state && (state_d == S_FETCH);

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        set_bus_err = 1'b0;
        set_illegal = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d     = S_HALT;
                    set_bus_err = 1'b1;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    default: begin
                        state_d     = S_HALT;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            // IR is held, so the opcode seen in DECODE is still valid here.
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timeout) begin
                    state_d     = S_HALT;
                    set_bus_err = 1'b1;
                end
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (timeout) begin
                    state_d     = S_HALT;
                    set_bus_err = 1'b1;
                end
            end
            S_EXEC:    state_d = S_RWB;
            S_ADDI_EX: state_d = S_ADDI_WB;
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDI_WB: state_d = S_FETCH;
            S_HALT:    state_d = S_HALT;
            // Unused encodings 12-14 are treated as a corrupted state.
            default: begin
                state_d     = S_HALT;
                set_illegal = 1'b1;
            end
        endcase
    end

    // State, wait counter, sticky flags, retired count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_FETCH;
            wait_cnt    <= '0;
            bus_err     <= 1'b0;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                wait_cnt <= '0;
            end else if ((WAIT_LIMIT > 0) && is_mem_state && !mem_ready) begin
                wait_cnt <= wait_cnt + WCW'(1);
            end
            if (set_bus_err) begin
                bus_err <= 1'b1;
            end
            if (set_illegal) begin
                illegal <= 1'b1;
            end
            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    // Control outputs: decoded from state; forced low while rst is held.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    // IR and PC+4 load exactly in the cycle the read completes.
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                end
                S_MEMADR, S_ADDI_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_RWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                S_ADDI_WB: begin
                    reg_write = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl

module tb_multicycle_ctrl;

    localparam int CNT_W = 3;
    localparam int WAIT_LIMIT = 15;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ILL  = 6'b111111;

    logic             clk = 1'b0;
    logic             rst;
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic             mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]       alu_src_b, alu_op, pc_source;
    logic [3:0]       state;
    logic             bus_err, illegal;
    logic [CNT_W-1:0] instr_count;

    multicycle_ctrl #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .bus_err(bus_err),
        .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         step;
        logic [3:0] st;
        logic [15:0] ctl;
        logic [31:0] cnt;
        logic       be;
        logic       il;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail = 0;
    int   step = 0;
    logic exp_be = 1'b0;
    logic exp_il = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Control word expected for a state, straight from the state table.
    // {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
    //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}
    function automatic logic [15:0] exp_ctl(input logic [3:0] s, input logic rdy);
        logic [15:0] c;
        c = 16'h0;
        case (s)
            4'd0:  begin c[12] = 1'b1; c[5:4] = 2'b01; c[10] = rdy; c[15] = rdy; end
            4'd1:  c[5:4] = 2'b11;
            4'd2, 4'd10: begin c[6] = 1'b1; c[5:4] = 2'b10; end
            4'd3:  begin c[12] = 1'b1; c[13] = 1'b1; end
            4'd4:  begin c[7] = 1'b1; c[9] = 1'b1; end
            4'd5:  begin c[11] = 1'b1; c[13] = 1'b1; end
            4'd6:  begin c[6] = 1'b1; c[3:2] = 2'b10; end
            4'd7:  begin c[7] = 1'b1; c[8] = 1'b1; end
            4'd8:  begin c[6] = 1'b1; c[3:2] = 2'b01; c[14] = 1'b1; c[1:0] = 2'b01; end
            4'd9:  begin c[15] = 1'b1; c[1:0] = 2'b10; end
            4'd11: c[7] = 1'b1;
            default: c = 16'h0;
        endcase
        return c;
    endfunction

    // Monitor: compares the oldest expectation against the DUT at the falling edge.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check($sformatf("state[%0d]", e.step), 32'(state), 32'(e.st));
            check($sformatf("ctl[%0d]", e.step),
                  32'({pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                       mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                       pc_source}), 32'(e.ctl));
            check($sformatf("instr_count[%0d]", e.step), 32'(instr_count), e.cnt);
            check($sformatf("bus_err[%0d]", e.step), 32'(bus_err), 32'(e.be));
            check($sformatf("illegal[%0d]", e.step), 32'(illegal), 32'(e.il));
        end
    end

    task automatic push(input logic [3:0] es, input logic [15:0] ctl, input int ecnt);
        exp_t x;
        x.step = step;
        x.st   = es;
        x.ctl  = ctl;
        x.cnt  = 32'(ecnt % (1 << CNT_W));
        x.be   = exp_be;
        x.il   = exp_il;
        sb.push_back(x);
        step++;
    endtask

    // One clock: drive inputs, record the expected observation for this cycle.
    task automatic cyc(input logic [5:0] op, input logic rdy, input logic [3:0] es, input int ecnt);
        opcode    = op;
        mem_ready = rdy;
        push(es, exp_ctl(es, rdy), ecnt);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // Two cycles of reset with mem_ready high: everything must read zero.
    task automatic do_reset();
        rst       = 1'b1;
        mem_ready = 1'b1;
        exp_be    = 1'b0;
        exp_il    = 1'b0;
        repeat (2) begin
            push(4'd0, 16'h0, 0);
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        opcode    = OP_R;
        mem_ready = 1'b0;
        do_reset();

        // R-type
        cyc(OP_R, 1, 0, 0); cyc(OP_R, 1, 1, 0); cyc(OP_R, 1, 6, 0); cyc(OP_R, 1, 7, 0);
        // lw, three stall cycles in MEMRD
        cyc(OP_LW, 1, 0, 1); cyc(OP_LW, 1, 1, 1); cyc(OP_LW, 1, 2, 1);
        repeat (3) cyc(OP_LW, 0, 3, 1);
        cyc(OP_LW, 1, 3, 1); cyc(OP_LW, 1, 4, 1);
        // sw, one FETCH stall and two MEMWR stalls
        cyc(OP_SW, 0, 0, 2); cyc(OP_SW, 1, 0, 2); cyc(OP_SW, 1, 1, 2); cyc(OP_SW, 1, 2, 2);
        repeat (2) cyc(OP_SW, 0, 5, 2);
        cyc(OP_SW, 1, 5, 2);
        // beq, j, addi
        cyc(OP_BEQ, 1, 0, 3); cyc(OP_BEQ, 1, 1, 3); cyc(OP_BEQ, 1, 8, 3);
        cyc(OP_J, 1, 0, 4); cyc(OP_J, 1, 1, 4); cyc(OP_J, 1, 9, 4);
        cyc(OP_ADDI, 1, 0, 5); cyc(OP_ADDI, 1, 1, 5); cyc(OP_ADDI, 1, 10, 5); cyc(OP_ADDI, 1, 11, 5);
        // two more R-types so the 3-bit counter wraps to 0 at eight retirements
        for (int k = 6; k < 8; k++) begin
            cyc(OP_R, 1, 0, k); cyc(OP_R, 1, 1, k); cyc(OP_R, 1, 6, k); cyc(OP_R, 1, 7, k);
        end
        cyc(OP_R, 1, 0, 8);

        // Illegal opcode: HALT with illegal, held for 20 cycles
        cyc(OP_ILL, 1, 1, 8);
        exp_il = 1'b1;
        repeat (20) cyc(OP_ILL, 1, 15, 8);
        do_reset();

        // FETCH timeout
        repeat (15) cyc(OP_R, 0, 0, 0);
        exp_be = 1'b1;
        repeat (3) cyc(OP_R, 0, 15, 0);
        do_reset();

        // Ready on the last tolerated cycle wins
        repeat (14) cyc(OP_R, 0, 0, 0);
        cyc(OP_R, 1, 0, 0); cyc(OP_R, 1, 1, 0); cyc(OP_R, 1, 6, 0); cyc(OP_R, 1, 7, 0);

        // MEMRD timeout
        cyc(OP_LW, 1, 0, 1); cyc(OP_LW, 1, 1, 1); cyc(OP_LW, 1, 2, 1);
        repeat (15) cyc(OP_LW, 0, 3, 1);
        exp_be = 1'b1;
        repeat (2) cyc(OP_LW, 0, 15, 1);
        do_reset();

        // Reset in the middle of a stalled MEMWR
        cyc(OP_SW, 1, 0, 0); cyc(OP_SW, 1, 1, 0); cyc(OP_SW, 1, 2, 0); cyc(OP_SW, 0, 5, 0);
        do_reset();
        cyc(OP_R, 1, 0, 0); cyc(OP_R, 1, 1, 0); cyc(OP_R, 1, 6, 0);

        @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
